vl_fnpipe: RTL and testbench

// - Parametrised, pipelined evaluator for the implicit-width function-argument ops exercised in the fns2

---
 rtl/vl_fnpipe_pkg.sv | 51 +++++
 rtl/vl_fnpipe_stage.sv | 47 ++++
 rtl/vl_fnpipe.sv | 95 +++++++++
 tb/tb_vl_fnpipe.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/vl_fnpipe_pkg.sv
// Shared opcode encoding and the combinational evaluator for vl_fnpipe.
// Operands are passed zero-extended to FN_MAX_W; r selects the effective argument width.
package vl_fnpipe_pkg;

    localparam int unsigned FN_MAX_W = 64;

    typedef enum logic [2:0] {
        OP_XOR1   = 3'd0,
        OP_AND1   = 3'd1,
        OP_ANDN   = 3'd2,
        OP_ANDMIX = 3'd3,
        OP_SLT    = 3'd4,
        OP_ULT    = 3'd5,
        OP_RSV6   = 3'd6,
        OP_RSV7   = 3'd7
    } op_e;

    function automatic logic [FN_MAX_W-1:0] fnpipe_eval(
        input op_e                 op,
        input logic [FN_MAX_W-1:0] a,
        input logic [FN_MAX_W-1:0] b,
        input int unsigned         r
    );
        logic [FN_MAX_W-1:0] mask;
        logic [FN_MAX_W-1:0] top_bit;
        logic [FN_MAX_W-1:0] am;
        logic [FN_MAX_W-1:0] bm;
        logic [FN_MAX_W-1:0] as;
        logic [FN_MAX_W-1:0] bs;
        logic [FN_MAX_W-1:0] res;
        mask    = (r >= FN_MAX_W) ? '1 : ((FN_MAX_W'(1) << r) - FN_MAX_W'(1));
        top_bit = mask & ~(mask >> 1);
        am      = a & mask;
        bm      = b & mask;
        // Sign-extend the r-bit arguments so a full-width signed compare matches an r-bit one
        as      = am | ((|(a & top_bit)) ? ~mask : '0);
        bs      = bm | ((|(b & top_bit)) ? ~mask : '0);
        res     = '0;
        case (op)
            OP_XOR1:   res[0] = a[0] ^ b[0];
            OP_AND1:   res[0] = a[0] & b[0];
            OP_ANDN:   res    = am & bm;
            OP_ANDMIX: res[0] = a[0] & b[0];
            OP_SLT:    res[0] = $signed(as) < $signed(bs);
            OP_ULT:    res[0] = am < bm;
            default:   res    = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/vl_fnpipe_stage.sv
// One elastic register slice: holds {valid,data}, loads when empty or draining this cycle.
module vl_fnpipe_stage #(
    parameter int unsigned DW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic          advance;
    logic          load;

    always_comb begin
        advance  = valid_q & out_ready;
        in_ready = !valid_q | advance;
        load     = in_valid & in_ready;
        valid_d  = valid_q;
        data_d   = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (advance) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/vl_fnpipe.sv
// Pipelined function evaluator: compute into stage 0, STAGES elastic slices, sticky bad-opcode count.
module vl_fnpipe
    import vl_fnpipe_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RES_WIDTH = 4,
    parameter int unsigned STAGES    = 2,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out,
    output logic                 bad_op,
    output logic [CNT_WIDTH-1:0] bad_cnt
);

    localparam int unsigned DW = RES_WIDTH + 1;

    logic [FN_MAX_W-1:0]  a_ext, b_ext;
    logic [RES_WIDTH-1:0] eval_res;
    logic                 is_rsv;
    logic                 accept;
    logic [CNT_WIDTH-1:0] bad_cnt_q, bad_cnt_d;

    logic          v [0:STAGES];
    logic [DW-1:0] d [0:STAGES];

    always_comb begin
        a_ext            = '0;
        b_ext            = '0;
        a_ext[WIDTH-1:0] = in1;
        b_ext[WIDTH-1:0] = in2;
        eval_res         = RES_WIDTH'(fnpipe_eval(op_e'(op), a_ext, b_ext, RES_WIDTH));
        is_rsv           = (op_e'(op) == OP_RSV6) || (op_e'(op) == OP_RSV7);
    end

    assign v[0] = in_valid;
    assign d[0] = {eval_res, is_rsv};

    // Each slice gets its own ready nets so the backward ready chain is not one looped array
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic rdy_up;
        logic rdy_dn;
        if (i == STAGES - 1) begin : g_last
            assign rdy_dn = out_ready;
        end else begin : g_mid
            assign rdy_dn = g_stage[i+1].rdy_up;
        end
        vl_fnpipe_stage #(.DW(DW)) u_stage (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (v[i]),
            .in_ready  (rdy_up),
            .in_data   (d[i]),
            .out_valid (v[i+1]),
            .out_ready (rdy_dn),
            .out_data  (d[i+1])
        );
    end

    assign in_ready = g_stage[0].rdy_up;
    assign accept   = in_valid & in_ready;

    always_comb begin
        bad_cnt_d = bad_cnt_q;
        if (accept && is_rsv && (bad_cnt_q != '1)) begin
            bad_cnt_d = bad_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bad_cnt_q <= '0;
        end else begin
            bad_cnt_q <= bad_cnt_d;
        end
    end

    always_comb begin
        out                  = '0;
        out[RES_WIDTH-1:0]   = d[STAGES][DW-1:1];
        bad_op               = d[STAGES][0];
        out_valid            = v[STAGES];
    end

    assign bad_cnt = bad_cnt_q;

endmodule

// File: tb/tb_vl_fnpipe.sv
// Directed bench for vl_fnpipe at default parameters with hand-computed expected results.
module tb_vl_fnpipe;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned RES_WIDTH = 4;
    localparam int unsigned STAGES    = 2;
    localparam int unsigned CNT_WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           op;
    logic [WIDTH-1:0]     in1, in2;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out;
    logic                 bad_op;
    logic [CNT_WIDTH-1:0] bad_cnt;

    int checks   = 0;
    int failures = 0;
    int unsigned exp_cnt = 0;

    logic [2:0]       s_op  [320];
    logic [WIDTH-1:0] s_a   [320];
    logic [WIDTH-1:0] s_b   [320];
    logic [WIDTH-1:0] s_exp [320];
    logic             s_bad [320];

    vl_fnpipe #(
        .WIDTH     (WIDTH),
        .RES_WIDTH (RES_WIDTH),
        .STAGES    (STAGES),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .bad_op    (bad_op),
        .bad_cnt   (bad_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic note_accept(input logic [2:0] o);
        if (o >= 3'd6 && exp_cnt < 255) exp_cnt++;
    endtask

    // Single item, out_ready high: output must appear exactly STAGES edges after the accept edge
    task automatic run_one(input string tag, input logic [2:0] o, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp,
                           input logic exp_bad);
        @(negedge clk);
        in_valid  = 1'b1;
        op        = o;
        in1       = a;
        in2       = b;
        out_ready = 1'b1;
        #1;
        check_eq({tag, "_in_ready"}, in_ready, 1'b1);
        @(posedge clk);
        note_accept(o);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq({tag, "_early_valid"}, out_valid, 1'b0);
        @(negedge clk);
        check_eq({tag, "_valid"}, out_valid, 1'b1);
        check_eq({tag, "_out"}, out, exp);
        check_eq({tag, "_bad_op"}, bad_op, exp_bad);
        check_eq({tag, "_bad_cnt"}, bad_cnt, exp_cnt);
    endtask

    task automatic run_stream(input string tag, input int n, input int stall_at, input int stall_len);
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        while (got < n && cyc < n + 40) begin
            @(negedge clk);
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            in_valid  = (sent < n);
            if (sent < n) begin
                op  = s_op[sent];
                in1 = s_a[sent];
                in2 = s_b[sent];
            end
            #1;
            if (out_valid && !out_ready) begin
                check_eq({tag, "_stall_out"}, out, s_exp[got]);
                check_eq({tag, "_stall_bad"}, bad_op, s_bad[got]);
                check_eq({tag, "_stall_in_ready"}, in_ready, (sent - got) < STAGES);
            end
            if (out_valid && out_ready) begin
                check_eq({tag, "_out"}, out, s_exp[got]);
                check_eq({tag, "_bad_op"}, bad_op, s_bad[got]);
                got++;
            end
            if (in_valid && in_ready) begin
                note_accept(op);
                sent++;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_eq({tag, "_count"}, got, n);
        check_eq({tag, "_bad_cnt"}, bad_cnt, exp_cnt);
    endtask

    task automatic set_item(input int k, input logic [2:0] o, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] e, input logic bd);
        s_op[k]  = o;
        s_a[k]   = a;
        s_b[k]   = b;
        s_exp[k] = e;
        s_bad[k] = bd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = 3'd0;
        in1       = '0;
        in2       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out", out, 8'h00);
        check_eq("rst_bad_op", bad_op, 1'b0);
        check_eq("rst_bad_cnt", bad_cnt, 8'h00);
        reset = 1'b0;
        #1;
        check_eq("rst_in_ready", in_ready, 1'b1);

        run_one("xor1_a",   3'd0, 8'h01, 8'h03, 8'h00, 1'b0);
        run_one("xor1_b",   3'd0, 8'h01, 8'h02, 8'h01, 1'b0);
        run_one("and1_a",   3'd1, 8'h03, 8'h01, 8'h01, 1'b0);
        run_one("and1_b",   3'd1, 8'h02, 8'h03, 8'h00, 1'b0);
        run_one("slt_a",    3'd4, 8'h08, 8'h01, 8'h01, 1'b0);
        run_one("ult_a",    3'd5, 8'h08, 8'h01, 8'h00, 1'b0);
        run_one("slt_b",    3'd4, 8'h17, 8'h0F, 8'h00, 1'b0);
        run_one("ult_b",    3'd5, 8'h17, 8'h0F, 8'h01, 1'b0);
        run_one("slt_c",    3'd4, 8'h0F, 8'h07, 8'h01, 1'b0);
        run_one("ult_c",    3'd5, 8'h0F, 8'h07, 8'h00, 1'b0);
        run_one("andmix_a", 3'd3, 8'hFF, 8'h0E, 8'h00, 1'b0);
        run_one("andmix_b", 3'd3, 8'hF1, 8'h0F, 8'h01, 1'b0);
        run_one("andn_a",   3'd2, 8'hFF, 8'h0E, 8'h0E, 1'b0);
        run_one("andn_b",   3'd2, 8'h5A, 8'hF3, 8'h02, 1'b0);
        run_one("rsv7",     3'd7, 8'hFF, 8'hFF, 8'h00, 1'b1);

        set_item(0, 3'd0, 8'h01, 8'h02, 8'h01, 1'b0);
        set_item(1, 3'd1, 8'h03, 8'h01, 8'h01, 1'b0);
        set_item(2, 3'd2, 8'hFF, 8'h0E, 8'h0E, 1'b0);
        set_item(3, 3'd5, 8'h08, 8'h01, 8'h00, 1'b0);
        set_item(4, 3'd6, 8'h12, 8'h34, 8'h00, 1'b1);
        set_item(5, 3'd4, 8'h08, 8'h01, 8'h01, 1'b0);
        run_stream("stall6", 6, 3, 3);

        for (int k = 0; k < 300; k++) begin
            set_item(k, 3'd7, 8'(k), 8'(k * 3), 8'h00, 1'b1);
        end
        run_stream("rsv300", 300, 1000, 0);
        check_eq("bad_cnt_sat", bad_cnt, 8'hFF);

        // Two items in flight, then reset coinciding with an attempted op-7 transfer
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op        = 3'd7;
        in1       = 8'h11;
        in2       = 8'h22;
        @(negedge clk);
        op        = 3'd1;
        in1       = 8'h03;
        in2       = 8'h01;
        @(negedge clk);
        check_eq("pre_rst_valid", out_valid, 1'b1);
        reset     = 1'b1;
        out_ready = 1'b1;
        op        = 3'd7;
        @(negedge clk);
        check_eq("mid_rst_out_valid", out_valid, 1'b0);
        check_eq("mid_rst_bad_cnt", bad_cnt, 8'h00);
        check_eq("mid_rst_out", out, 8'h00);
        check_eq("mid_rst_bad_op", bad_op, 1'b0);
        reset    = 1'b0;
        in_valid = 1'b0;
        exp_cnt  = 0;
        #1;
        check_eq("mid_rst_in_ready", in_ready, 1'b1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq("post_rst_no_stale", out_valid, 1'b0);
        end
        run_one("post_rst_item", 3'd0, 8'h01, 8'h02, 8'h01, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
